// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl
// -----------------------------------------------------------------------------
// Run controller for the single-cycle MIPS core. It has three phases:
//   1. It loads a program into instruction memory from a ready/valid word
//      stream. The stream ends on ld_last or when memory is full.
//   2. On start it holds the PC in reset for one cycle. It then enables the
//      core until the PC repeats, which means the program parked in a
//      self-loop, or until MAX_CYCLES run cycles have elapsed.
//   3. It streams all 32 register-file values out over a ready/valid port,
//      then sits in DONE.
//
// Optional feature macro: RUN_CTRL_DUMP_EN
//   defined   : the register dump phase is present.
//   undefined : RUN goes straight to DONE. dump_valid, dump_idx and rf_raddr
//               are constant 0, and dump_ready is ignored.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   ld_valid/ld_data/ld_last  program word stream in
//   ld_ready                  controller accepts a program word
//   start                     one-cycle run request (IDLE/DONE only)
//   imem_we/addr/wdata        instruction-memory write port
//   cpu_run                   core clock-enable
//   cpu_pc_rst                forces the core PC to 0
//   cpu_pc                    current core PC
//   rf_raddr/rf_rdata         register-file debug read port
//   dump_valid/idx/data/ready register dump stream out
//   done, timeout             run finished / run ended by the cycle budget
//   cycles                    RUN cycles used by the last run
//   words                     words written by the last load
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8,
    parameter int MAX_CYCLES = 3116
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              cpu_pc_rst,
    input  logic [31:0]       cpu_pc,
    output logic [4:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              dump_valid,
    output logic [4:0]        dump_idx,
    output logic [31:0]       dump_data,
    input  logic              dump_ready,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycles,
    output logic [ADDR_W:0]   words
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PCRST = 3'd2,
        S_RUN   = 3'd3,
        S_DUMP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wptr_reg, wptr_next;
    logic [ADDR_W:0]   words_reg, words_next;
    logic [31:0]       cycles_reg, cycles_next;
    logic [31:0]       prev_pc_reg, prev_pc_next;
    logic [4:0]        dump_idx_reg, dump_idx_next;
    logic              done_reg, done_next;
    logic              timeout_reg, timeout_next;
    // Set when a load was cut off at the last memory address. It keeps the
    // surplus words of that stream waiting instead of letting them start a
    // fresh load from IDLE. An accepted start releases it.
    logic              full_reg, full_next;

    logic              idle_like;
    logic              start_ok;
    logic              ld_open;
    logic              ld_hs;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       cycles_inc;
    logic              halt;
    logic              budget_hit;

    assign idle_like  = (state_reg == S_IDLE) || (state_reg == S_DONE);
    assign start_ok   = start && idle_like;
    // If start and a word arrive together, start wins and the word waits.
    assign ld_open    = (idle_like || (state_reg == S_LOAD)) && !full_reg && !start_ok;
    assign ld_hs      = ld_valid && ld_open;
    // A load that begins from IDLE/DONE always writes its first word at 0.
    assign ld_addr    = idle_like ? '0 : wptr_reg;
    assign cycles_inc = cycles_reg + 32'd1;
    // cycles_reg is 0 only in the first RUN cycle. At that point prev_pc
    // still holds a stale value, so no halt can be detected yet.
    assign halt       = (cycles_reg != 32'd0) && (cpu_pc == prev_pc_reg);
    assign budget_hit = (cycles_inc == 32'(MAX_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wptr_reg     <= '0;
            words_reg    <= '0;
            cycles_reg   <= '0;
            prev_pc_reg  <= '0;
            dump_idx_reg <= '0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            full_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wptr_reg     <= wptr_next;
            words_reg    <= words_next;
            cycles_reg   <= cycles_next;
            prev_pc_reg  <= prev_pc_next;
            dump_idx_reg <= dump_idx_next;
            done_reg     <= done_next;
            timeout_reg  <= timeout_next;
            full_reg     <= full_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wptr_next     = wptr_reg;
        words_next    = words_reg;
        cycles_next   = cycles_reg;
        prev_pc_next  = prev_pc_reg;
        dump_idx_next = dump_idx_reg;
        done_next     = done_reg;
        timeout_next  = timeout_reg;
        full_next     = full_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_LOAD: begin
                if (start_ok) begin
                    state_next   = S_PCRST;
                    cycles_next  = '0;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    full_next    = 1'b0;
                end else if (ld_hs) begin
                    wptr_next    = ld_addr + 1'b1;
                    words_next   = ((state_reg == S_LOAD) ? words_reg : '0) + 1'b1;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    if (ld_last) begin
                        state_next = S_IDLE;
                    end else if (ld_addr == ADDR_W'(IMEM_DEPTH - 1)) begin
                        state_next = S_IDLE;
                        full_next  = 1'b1;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end

            S_PCRST: begin
                state_next = S_RUN;
            end

            S_RUN: begin
                cycles_next  = cycles_inc;
                prev_pc_next = cpu_pc;
                if (halt || budget_hit) begin
                    // A halt on the budget cycle still counts as a clean halt.
                    timeout_next = !halt;
`ifdef RUN_CTRL_DUMP_EN
                    state_next    = S_DUMP;
                    dump_idx_next = '0;
`else
                    state_next    = S_DONE;
                    done_next     = 1'b1;
`endif
                end
            end

`ifdef RUN_CTRL_DUMP_EN
            S_DUMP: begin
                if (dump_ready) begin
                    // The index wraps from 31 to 0 on the final handshake.
                    dump_idx_next = dump_idx_reg + 5'd1;
                    if (dump_idx_reg == 5'd31) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign ld_ready   = ld_open;
    assign imem_we    = ld_hs;
    assign imem_addr  = ld_addr;
    assign imem_wdata = ld_data;
    assign cpu_run    = (state_reg == S_RUN);
    assign cpu_pc_rst = (state_reg == S_PCRST);
    assign done       = done_reg;
    assign timeout    = timeout_reg;
    assign cycles     = cycles_reg;
    assign words      = words_reg;
    // The register value is passed straight through. The index only moves
    // on a handshake, so the data stays stable while the consumer stalls.
    assign dump_data  = rf_rdata;

`ifdef RUN_CTRL_DUMP_EN
    assign dump_valid = (state_reg == S_DUMP);
    assign dump_idx   = dump_idx_reg;
    assign rf_raddr   = dump_idx_reg;
`else
    logic unused_dump_ready;
    assign unused_dump_ready = dump_ready;
    assign dump_valid = 1'b0;
    assign dump_idx   = 5'd0;
    assign rf_raddr   = 5'd0;
`endif

endmodule
